// File: rtl/vx_dcr_launch_seq.sv
// vx_dcr_launch_seq: host-side DCR write sequencer feeding the KMU.
// Buffers {addr, data} DCR writes, replays them one per cycle on commit,
// then waits for kmu_start and reports done.
// Optional feature macro: VX_DCR_SEQ_TIMEOUT_EN adds a start-wait timeout.
// Widths come from VX_DCR_ADDR_WIDTH / VX_DCR_DATA_WIDTH (defaults below).

`ifndef VX_DCR_ADDR_WIDTH
`define VX_DCR_ADDR_WIDTH 12
`endif
`ifndef VX_DCR_DATA_WIDTH
`define VX_DCR_DATA_WIDTH 32
`endif

module vx_dcr_launch_seq #(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           push_valid,
   input  logic [`VX_DCR_ADDR_WIDTH-1:0]  push_addr,
   input  logic [`VX_DCR_DATA_WIDTH-1:0]  push_data,
   output logic                           push_ready,
   input  logic                           commit,
   output logic                           dcr_wr_valid,
   output logic [`VX_DCR_ADDR_WIDTH-1:0]  dcr_wr_addr,
   output logic [`VX_DCR_DATA_WIDTH-1:0]  dcr_wr_data,
   input  logic                           kmu_start,
   output logic                           busy,
   output logic                           done,
   output logic                           timeout,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int AW = `VX_DCR_ADDR_WIDTH;
   localparam int DW = `VX_DCR_DATA_WIDTH;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_WAIT  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [AW+DW-1:0]  mem_q [DEPTH];
   logic              wr_valid_q, wr_valid_d;
   logic [AW-1:0]     wr_addr_q, wr_addr_d;
   logic [DW-1:0]     wr_data_q, wr_data_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              push_acc;
   logic              pop;
   logic [AW+DW-1:0]  pop_entry;

`ifdef VX_DCR_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT+1);
   logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
   logic              timeout_q, timeout_d;
`else
   // TIMEOUT only matters when the timeout feature is built in.
   logic              unused_timeout;
   assign unused_timeout = ^TIMEOUT;
`endif

   assign push_ready = (state_q == S_IDLE) && (count_q < CW'(DEPTH));
   assign push_acc   = push_valid && push_ready;

   // Next-state, pointer/occupancy update and registered output values.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves a latch.
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = '0;
      wr_data_d  = '0;
      done_d     = 1'b0;
      pop        = 1'b0;
      // An empty buffer can only be committed together with a push: forward it.
      pop_entry  = (count_q != '0) ? mem_q[rd_ptr_q] : {push_addr, push_data};
`ifdef VX_DCR_SEQ_TIMEOUT_EN
      tmo_cnt_d  = tmo_cnt_q;
      timeout_d  = 1'b0;
`endif

      if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);

      case (state_q)
         S_IDLE: begin
            if (commit && ((count_q != '0) || push_acc)) begin
               state_d = S_DRAIN;
               pop     = 1'b1;
            end
         end
         S_DRAIN: begin
            if (count_q != '0) begin
               pop = 1'b1;
            end else begin
               state_d = S_WAIT;
`ifdef VX_DCR_SEQ_TIMEOUT_EN
               tmo_cnt_d = '0;
`endif
            end
         end
         S_WAIT: begin
            if (kmu_start) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
`ifdef VX_DCR_SEQ_TIMEOUT_EN
            else if (tmo_cnt_q == TW'(TIMEOUT-1)) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase

      if (pop) begin
         wr_valid_d             = 1'b1;
         {wr_addr_d, wr_data_d} = pop_entry;
         rd_ptr_d               = rd_ptr_q + PW'(1);
      end

      count_d = count_q + CW'(push_acc) - CW'(pop);
      busy_d  = (state_d != S_IDLE);
   end

   // State, pointers, occupancy and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   // Buffer storage, written on every accepted push.
   // NOTE: the array is not reset; pointers and occupancy decide which entries are live.
   always_ff @(posedge clk) begin
      if (push_acc) mem_q[wr_ptr_q] <= {push_addr, push_data};
   end

`ifdef VX_DCR_SEQ_TIMEOUT_EN
   // Start-wait counter and timeout pulse register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign dcr_wr_valid = wr_valid_q;
   assign dcr_wr_addr  = wr_addr_q;
   assign dcr_wr_data  = wr_data_q;
   assign done         = done_q;
   assign busy         = busy_q;
   assign count        = count_q;

endmodule

// File: tb/tb_vx_dcr_launch_seq.sv
// Self-checking bench for vx_dcr_launch_seq: directed scenarios followed by
// random traffic, every cycle compared against a queue-based launch model.

`ifndef VX_DCR_ADDR_WIDTH
`define VX_DCR_ADDR_WIDTH 12
`endif
`ifndef VX_DCR_DATA_WIDTH
`define VX_DCR_DATA_WIDTH 32
`endif

module tb_vx_dcr_launch_seq;

   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 8;
   localparam int AW      = `VX_DCR_ADDR_WIDTH;
   localparam int DW      = `VX_DCR_DATA_WIDTH;
   localparam int CW      = $clog2(DEPTH+1);

   typedef logic [AW+DW-1:0] pair_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          push_valid = 1'b0;
   logic [AW-1:0] push_addr = '0;
   logic [DW-1:0] push_data = '0;
   logic          push_ready;
   logic          commit = 1'b0;
   logic          dcr_wr_valid;
   logic [AW-1:0] dcr_wr_addr;
   logic [DW-1:0] dcr_wr_data;
   logic          kmu_start = 1'b0;
   logic          busy;
   logic          done;
   logic          timeout;
   logic [CW-1:0] count;

   always #5 clk = ~clk;

   vx_dcr_launch_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .reset        (reset),
      .push_valid   (push_valid),
      .push_addr    (push_addr),
      .push_data    (push_data),
      .push_ready   (push_ready),
      .commit       (commit),
      .dcr_wr_valid (dcr_wr_valid),
      .dcr_wr_addr  (dcr_wr_addr),
      .dcr_wr_data  (dcr_wr_data),
      .kmu_start    (kmu_start),
      .busy         (busy),
      .done         (done),
      .timeout      (timeout),
      .count        (count)
   );

   // Reference model: host buffer, launch in flight, and launch phase.
   pair_t   host_buf[$];
   pair_t   in_flight[$];
   int      phase;      // 0 = accepting, 1 = replaying, 2 = awaiting start
   int      waited;     // cycles spent awaiting start
   logic    exp_valid, exp_done, exp_tmo, exp_busy, exp_ready;
   pair_t   exp_pair;
   int      exp_count;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs the DUT sampled.
   task automatic model_edge();
      exp_valid = 1'b0;
      exp_pair  = '0;
      exp_done  = 1'b0;
      exp_tmo   = 1'b0;
      if (!reset) begin
         host_buf.delete();
         in_flight.delete();
         phase  = 0;
         waited = 0;
      end else begin
         if (push_valid && phase == 0 && host_buf.size() < DEPTH)
            host_buf.push_back({push_addr, push_data});
         if (phase == 0) begin
            if (commit && host_buf.size() > 0) begin
               in_flight = host_buf;
               host_buf.delete();
               phase     = 1;
               exp_valid = 1'b1;
               exp_pair  = in_flight.pop_front();
            end
         end else if (phase == 1) begin
            if (in_flight.size() > 0) begin
               exp_valid = 1'b1;
               exp_pair  = in_flight.pop_front();
            end else begin
               phase  = 2;
               waited = 0;
            end
         end else begin
            if (kmu_start) begin
               exp_done = 1'b1;
               phase    = 0;
            end
`ifdef VX_DCR_SEQ_TIMEOUT_EN
            else if (waited == TIMEOUT-1) begin
               exp_tmo = 1'b1;
               phase   = 0;
            end
`endif
            else begin
               waited++;
            end
         end
      end
      exp_busy  = (phase != 0);
      exp_count = host_buf.size() + in_flight.size();
      exp_ready = (phase == 0) && (exp_count < DEPTH);
   endtask

   // One clock: drive inputs at negedge, update model at posedge, compare just after.
   task automatic step(input logic pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                       input logic cm, input logic ks, input logic rs);
      @(negedge clk);
      push_valid = pv;
      push_addr  = pa;
      push_data  = pd;
      commit     = cm;
      kmu_start  = ks;
      reset      = rs;
      @(posedge clk);
      model_edge();
      #1;
      check("dcr_wr_valid", 64'(dcr_wr_valid), 64'(exp_valid));
      check("dcr_wr_addr",  64'(dcr_wr_addr),  64'(exp_pair[AW+DW-1:DW]));
      check("dcr_wr_data",  64'(dcr_wr_data),  64'(exp_pair[DW-1:0]));
      check("done",         64'(done),         64'(exp_done));
      check("timeout",      64'(timeout),      64'(exp_tmo));
      check("busy",         64'(busy),         64'(exp_busy));
      check("count",        64'(count),        64'(exp_count));
      check("push_ready",   64'(push_ready),   64'(exp_ready));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
      step(1'b1, a, d, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic do_commit();
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic start_pulse();
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
   endtask

   initial begin
      phase  = 0;
      waited = 0;

      // Reset held for a few edges.
      for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      idle(1);

      // Basic launch: three writes in order, start two cycles after the last write.
      push(AW'('h001), DW'('hA0));
      push(AW'('h002), DW'('hB0));
      push(AW'('h003), DW'('hC0));
      do_commit();
      idle(3);
      start_pulse();
      idle(2);

      // Full buffer: 17 back-to-back pushes, the last one is refused; drain wraps.
      for (int i = 0; i < 17; i++) push(AW'(i + 'h10), DW'(32'h1000 + i));
      do_commit();
      idle(17);
      start_pulse();
      idle(2);

      // Commit with an empty buffer does nothing.
      do_commit();
      idle(2);

      // Push and commit together on an empty buffer: one write of the pushed pair.
      step(1'b1, AW'('h0AB), DW'('hCAFE), 1'b1, 1'b0, 1'b1);
      idle(2);
      start_pulse();
      idle(1);

      // kmu_start during drain is ignored; push during drain is dropped.
      push(AW'('h021), DW'('h11));
      push(AW'('h022), DW'('h22));
      push(AW'('h023), DW'('h33));
      do_commit();
      start_pulse();
      step(1'b1, AW'('h0EE), DW'('hEE), 1'b0, 1'b0, 1'b1);
      idle(3);
      start_pulse();
      idle(2);

`ifdef VX_DCR_SEQ_TIMEOUT_EN
      // No start: timeout expires after TIMEOUT waiting cycles.
      push(AW'('h031), DW'('h44));
      do_commit();
      idle(TIMEOUT + 4);
      // Start arriving exactly in the expiry cycle wins over the timeout.
      push(AW'('h032), DW'('h55));
      do_commit();
      for (int i = 0; i < TIMEOUT + 4; i++)
         step(1'b0, '0, '0, 1'b0, (phase == 2 && waited == TIMEOUT-1), 1'b1);
`endif

      // Reset during the second of four writes, then a normal single-entry launch.
      for (int i = 0; i < 4; i++) push(AW'(i + 'h40), DW'(32'h4000 + i));
      do_commit();
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      idle(2);
      push(AW'('h050), DW'('h5050));
      do_commit();
      idle(1);
      start_pulse();
      idle(1);

      // Random traffic with occasional mid-operation resets.
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 99) < 45,
              AW'($urandom()), DW'($urandom()),
              $urandom_range(0, 99) < 8,
              $urandom_range(0, 99) < 10,
              $urandom_range(0, 199) != 0);
      end
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
